// File: rtl/raster_addr_gen.sv
// Raster address generator: walks a W x H window row- or column-major, one address per beat.
// First beat valid one cycle after start; outputs hold under backpressure, abort returns to IDLE.
module raster_addr_gen #(
    parameter int DIM_W  = 9,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              col_major,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DIM_W-1:0]  x_cnt,
    output logic [DIM_W-1:0]  y_cnt,
    output logic              last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic              cfg_col;
    logic [DIM_W-1:0]  cfg_w;
    logic [DIM_W-1:0]  cfg_h;
    logic [ADDR_W-1:0] cfg_stride;
    // Start address of the current outer-loop line: row start (row-major) or column top (column-major).
    logic [ADDR_W-1:0] line_acc;
    logic [ADDR_W-1:0] line_next;
    logic              x_end;
    logic              y_end;

    assign x_end     = (x_cnt == cfg_w - DIM_W'(1));
    assign y_end     = (y_cnt == cfg_h - DIM_W'(1));
    assign line_next = cfg_col ? (line_acc + ADDR_W'(1)) : (line_acc + cfg_stride);

    assign out_valid = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign last      = out_valid && x_end && y_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cfg_col    <= 1'b0;
            cfg_w      <= '0;
            cfg_h      <= '0;
            cfg_stride <= '0;
            line_acc   <= '0;
            addr_out   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
        end else if (abort) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_col    <= col_major;
                        cfg_w      <= img_w;
                        cfg_h      <= img_h;
                        cfg_stride <= stride;
                        line_acc   <= base_addr;
                        addr_out   <= base_addr;
                        x_cnt      <= '0;
                        y_cnt      <= '0;
                        state      <= (img_w == '0 || img_h == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (last) begin
                            state <= S_DONE;
                        end else if (!cfg_col) begin
                            if (x_end) begin
                                x_cnt    <= '0;
                                y_cnt    <= y_cnt + DIM_W'(1);
                                line_acc <= line_next;
                                addr_out <= line_next;
                            end else begin
                                x_cnt    <= x_cnt + DIM_W'(1);
                                addr_out <= addr_out + ADDR_W'(1);
                            end
                        end else begin
                            if (y_end) begin
                                y_cnt    <= '0;
                                x_cnt    <= x_cnt + DIM_W'(1);
                                line_acc <= line_next;
                                addr_out <= line_next;
                            end else begin
                                y_cnt    <= y_cnt + DIM_W'(1);
                                addr_out <= addr_out + cfg_stride;
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen: scan orders, backpressure, edge windows, wrap, abort and reset.
module tb_raster_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, col_major, out_ready;
    logic [8:0]  img_w, img_h;
    logic [16:0] stride, base_addr;
    logic        out_valid, last, busy, done;
    logic [16:0] addr_out;
    logic [8:0]  x_cnt, y_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    logic [16:0] q_addr[$];
    logic [8:0]  q_x[$];
    logic [8:0]  q_y[$];
    logic        q_last[$];
    bit          done_seen;
    int          done_gap;

    raster_addr_gen #(.DIM_W(9), .ADDR_W(17)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .col_major(col_major),
        .img_w(img_w), .img_h(img_h), .stride(stride), .base_addr(base_addr),
        .out_valid(out_valid), .out_ready(out_ready), .addr_out(addr_out),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic start_scan(input logic cm, input logic [8:0] w, input logic [8:0] h,
                              input logic [16:0] s, input logic [16:0] b);
        col_major = cm; img_w = w; img_h = h; stride = s; base_addr = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        col_major = 1'b0; img_w = '0; img_h = '0; stride = '0; base_addr = '0;
    endtask

    // Records every accepted beat until the done pulse or the cycle budget runs out.
    task automatic collect(input bit rnd, input int budget);
        int c_last;
        c_last = -100;
        q_addr.delete(); q_x.delete(); q_y.delete(); q_last.delete();
        done_seen = 1'b0;
        done_gap  = 0;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                done_seen = 1'b1;
                done_gap  = c - c_last;
                break;
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                q_addr.push_back(addr_out);
                q_x.push_back(x_cnt);
                q_y.push_back(y_cnt);
                q_last.push_back(last);
                if (last) c_last = c;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({out_valid, busy, done, last, addr_out, x_cnt, y_cnt} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got v=%b b=%b d=%b l=%b a=%h x=%0d y=%0d, expected all 0",
                     out_valid, busy, done, last, addr_out, x_cnt, y_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_fails++;
            $display("FAIL idle_after_reset: got v/b/d=%b%b%b, expected 000", out_valid, busy, done);
        end
    endtask

    task automatic test_row_major;
        logic [16:0] exp_a[6];
        exp_a = '{17'h100, 17'h101, 17'h102, 17'h240, 17'h241, 17'h242};
        start_scan(1'b0, 9'd3, 9'd2, 17'd320, 17'h100);
        n_checks++;
        if (out_valid !== 1'b1 || addr_out !== 17'h100 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL row_first_beat: got v=%b a=%h b=%b, expected v=1 a=100 b=1", out_valid, addr_out, busy);
        end
        collect(1'b0, 50);
        n_checks++;
        if (q_addr.size() != 6) begin
            n_fails++;
            $display("FAIL row_beat_count: got %0d, expected 6", q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (q_addr[i] !== exp_a[i] || q_last[i] !== (i == 5) ||
                    q_x[i] !== 9'(i % 3) || q_y[i] !== 9'(i / 3)) begin
                    n_fails++;
                    $display("FAIL row_beat%0d: got a=%h x=%0d y=%0d l=%b, expected a=%h x=%0d y=%0d l=%b",
                             i, q_addr[i], q_x[i], q_y[i], q_last[i], exp_a[i], i % 3, i / 3, i == 5);
                end
            end
        end
        n_checks++;
        if (!done_seen || done_gap != 1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL row_done: got seen=%b gap=%0d v=%b, expected seen=1 gap=1 v=0", done_seen, done_gap, out_valid);
        end
    endtask

    task automatic test_col_major;
        logic [16:0] exp_a[6];
        exp_a = '{17'h100, 17'h240, 17'h101, 17'h241, 17'h102, 17'h242};
        @(negedge clk);
        start_scan(1'b1, 9'd3, 9'd2, 17'd320, 17'h100);
        collect(1'b0, 50);
        n_checks++;
        if (q_addr.size() != 6) begin
            n_fails++;
            $display("FAIL col_beat_count: got %0d, expected 6", q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (q_addr[i] !== exp_a[i] || q_last[i] !== (i == 5) ||
                    q_x[i] !== 9'(i / 2) || q_y[i] !== 9'(i % 2)) begin
                    n_fails++;
                    $display("FAIL col_beat%0d: got a=%h x=%0d y=%0d l=%b, expected a=%h x=%0d y=%0d l=%b",
                             i, q_addr[i], q_x[i], q_y[i], q_last[i], exp_a[i], i / 2, i % 2, i == 5);
                end
            end
        end
        n_checks++;
        if (!done_seen || done_gap != 1) begin
            n_fails++;
            $display("FAIL col_done: got seen=%b gap=%0d, expected seen=1 gap=1", done_seen, done_gap);
        end
    endtask

    task automatic test_backpressure;
        int c_last, nacc, gap;
        bit stall, dseen;
        logic [16:0] pa, ea;
        c_last = -100; nacc = 0; gap = 0; stall = 1'b0; dseen = 1'b0; pa = '0;
        @(negedge clk);
        start_scan(1'b0, 9'd4, 9'd4, 17'h10, 17'h20);
        for (int c = 0; c < 300; c++) begin
            if (done) begin
                dseen = 1'b1;
                gap   = c - c_last;
                break;
            end
            if (stall) begin
                n_checks++;
                if (addr_out !== pa || out_valid !== 1'b1) begin
                    n_fails++;
                    $display("FAIL bp_hold: got a=%h v=%b, expected a=%h v=1", addr_out, out_valid, pa);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                ea = 17'(32'h20 + (nacc / 4) * 16 + (nacc % 4));
                n_checks++;
                if (addr_out !== ea || last !== (nacc == 15)) begin
                    n_fails++;
                    $display("FAIL bp_beat%0d: got a=%h l=%b, expected a=%h l=%b", nacc, addr_out, last, ea, nacc == 15);
                end
                if (last) c_last = c;
                nacc++;
            end
            stall = out_valid && !out_ready;
            pa    = addr_out;
            @(negedge clk);
        end
        n_checks++;
        if (nacc != 16 || !dseen || gap != 1) begin
            n_fails++;
            $display("FAIL bp_complete: got beats=%0d done=%b gap=%0d, expected 16 1 1", nacc, dseen, gap);
        end
    endtask

    task automatic test_edge_windows;
        @(negedge clk);
        out_ready = 1'b1;
        start_scan(1'b0, 9'd0, 9'd5, 17'd8, 17'h55);
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_w: got d=%b v=%b, expected d=1 v=0", done, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL zero_w_after: got d=%b v=%b, expected d=0 v=0", done, out_valid);
        end
        start_scan(1'b1, 9'd1, 9'd1, 17'd8, 17'h1234);
        n_checks++;
        if (out_valid !== 1'b1 || last !== 1'b1 || addr_out !== 17'h1234) begin
            n_fails++;
            $display("FAIL one_px: got v=%b l=%b a=%h, expected v=1 l=1 a=1234", out_valid, last, addr_out);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL one_px_done: got d=%b v=%b, expected d=1 v=0", done, out_valid);
        end
    endtask

    task automatic test_start_during_run;
        logic [16:0] exp_a[6];
        exp_a = '{17'h100, 17'h101, 17'h102, 17'h240, 17'h241, 17'h242};
        @(negedge clk);
        out_ready = 1'b0;
        start_scan(1'b0, 9'd3, 9'd2, 17'd320, 17'h100);
        start_scan(1'b1, 9'd7, 9'd7, 17'd1, 17'h555);
        collect(1'b0, 50);
        n_checks++;
        if (q_addr.size() != 6) begin
            n_fails++;
            $display("FAIL restart_ignored_count: got %0d, expected 6", q_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (q_addr[i] !== exp_a[i]) begin
                    n_fails++;
                    $display("FAIL restart_ignored_beat%0d: got %h, expected %h", i, q_addr[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [16:0] exp_a[4];
        exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        @(negedge clk);
        start_scan(1'b0, 9'd4, 9'd1, 17'd1, 17'h1FFFE);
        collect(1'b0, 50);
        n_checks++;
        if (q_addr.size() != 4 || !done_seen) begin
            n_fails++;
            $display("FAIL wrap_count: got %0d done=%b, expected 4 done=1", q_addr.size(), done_seen);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_addr[i] !== exp_a[i]) begin
                    n_fails++;
                    $display("FAIL wrap_beat%0d: got %h, expected %h", i, q_addr[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_abort_restart;
        bit dseen;
        logic [16:0] exp_a[4];
        exp_a = '{17'h10, 17'h18, 17'h11, 17'h19};
        dseen = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        start_scan(1'b0, 9'd3, 9'd2, 17'd320, 17'h100);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (addr_out !== 17'h102 || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL abort_third_beat: got a=%h v=%b, expected a=102 v=1", addr_out, out_valid);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({out_valid, busy, last, done} !== 4'b0000) begin
            n_fails++;
            $display("FAIL abort_clear: got v/b/l/d=%b%b%b%b, expected 0000", out_valid, busy, last, done);
        end
        for (int c = 0; c < 5; c++) begin
            if (done || out_valid) dseen = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (dseen) begin
            n_fails++;
            $display("FAIL abort_no_done: got activity=1, expected 0");
        end
        start_scan(1'b1, 9'd2, 9'd2, 17'h8, 17'h10);
        collect(1'b0, 50);
        n_checks++;
        if (q_addr.size() != 4 || !done_seen) begin
            n_fails++;
            $display("FAIL restart_count: got %0d done=%b, expected 4 done=1", q_addr.size(), done_seen);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_addr[i] !== exp_a[i]) begin
                    n_fails++;
                    $display("FAIL restart_beat%0d: got %h, expected %h", i, q_addr[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk);
        out_ready = 1'b1;
        start_scan(1'b0, 9'd4, 9'd4, 17'h10, 17'h300);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, busy, done, last, addr_out, x_cnt, y_cnt} !== '0) begin
            n_fails++;
            $display("FAIL async_reset: got v=%b b=%b d=%b l=%b a=%h x=%0d y=%0d, expected all 0",
                     out_valid, busy, done, last, addr_out, x_cnt, y_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; col_major = 1'b0; out_ready = 1'b0;
        img_w = '0; img_h = '0; stride = '0; base_addr = '0;
        test_reset();
        test_row_major();
        test_col_major();
        test_backpressure();
        test_edge_windows();
        test_start_during_run();
        test_wrap();
        test_abort_restart();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
